// File: rtl/fft32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft32_pkg : shared constants and FSM state type for the FFT32 seq. |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package fft32_pkg;
  localparam int N          = 32;
  localparam int LOG2N      = 5;
  localparam int NUM_BF     = 16;
  localparam int TW_IDX_W   = 4;
  localparam int ADDR_W     = 5;
  localparam int STAGE_W    = 3;
  localparam int BF_W       = 4;
  localparam int LAST_STAGE = LOG2N - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage
`default_nettype wire

// File: rtl/fft32_bf_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft32_bf_sequencer_if : butterfly beat bus (sequencer -> datapath) |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
interface fft32_bf_sequencer_if;
  import fft32_pkg::*;

  logic                bf_valid;
  logic                bf_ready;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_b;
  logic [TW_IDX_W-1:0] tw_idx;
  logic [STAGE_W-1:0]  stage;
  logic                last_bf;

  modport master (
    output bf_valid, addr_a, addr_b, tw_idx, stage, last_bf,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, addr_a, addr_b, tw_idx, stage, last_bf,
    output bf_ready
  );
endinterface
`default_nettype wire

// File: rtl/fft32_bf_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft32_bf_addr_gen : (stage, butterfly) -> operand addrs + twiddle  |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module fft32_bf_addr_gen
  import fft32_pkg::*;
(
  input  logic [STAGE_W-1:0]  stage_i,
  input  logic [BF_W-1:0]     b_i,
  output logic [ADDR_W-1:0]   addr_a_o,
  output logic [ADDR_W-1:0]   addr_b_o,
  output logic [TW_IDX_W-1:0] tw_idx_o
);
  logic [ADDR_W-1:0] w_half;
  logic [BF_W-1:0]   w_mask;
  logic [BF_W-1:0]   w_pos;
  logic [BF_W-1:0]   w_grp_base;

  assign w_half     = ADDR_W'((N / 2) >> stage_i);
  assign w_mask     = BF_W'(w_half - 5'd1);
  assign w_pos      = b_i & w_mask;
  // b & ~mask equals grp*half, so one left shift gives grp*2*half
  assign w_grp_base = b_i & ~w_mask;

  assign addr_a_o = {w_grp_base, 1'b0} | {1'b0, w_pos};
  assign addr_b_o = addr_a_o | w_half;
  assign tw_idx_o = TW_IDX_W'(w_pos << stage_i);
endmodule
`default_nettype wire

// File: rtl/fft32_bf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft32_bf_sequencer : 5-stage x 16-butterfly DIF FFT32 sequencer    |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module fft32_bf_sequencer
  import fft32_pkg::*;
#(
  parameter int BF_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  fft32_bf_sequencer_if.master bf_if
);
  localparam int GAP_W    = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam int GAP_LAST = (BF_LATENCY > 0) ? BF_LATENCY - 1 : 0;

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [BF_W-1:0]     b_q, b_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
  logic [TW_IDX_W-1:0] tw_q;
  logic [ADDR_W-1:0]   w_addr_a, w_addr_b;
  logic [TW_IDX_W-1:0] w_tw;
  logic                w_fire;
  logic                w_stage_end;

  assign w_fire = valid_q & bf_if.bf_ready;

  // Addresses are computed from the next (stage, b) so they land registered
  fft32_bf_addr_gen u_addr_gen (
    .stage_i  (stage_d),
    .b_i      (b_d),
    .addr_a_o (w_addr_a),
    .addr_b_o (w_addr_b),
    .tw_idx_o (w_tw)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    b_d         = b_q;
    gap_d       = gap_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    w_stage_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          stage_d = '0;
          b_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_fire) begin
          if (b_q != BF_W'(NUM_BF - 1)) begin
            b_d = b_q + 4'd1;
          end else if (BF_LATENCY == 0) begin
            w_stage_end = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          w_stage_end = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        stage_d = '0;
        b_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_stage_end) begin
      gap_d = '0;
      if (stage_q == STAGE_W'(LAST_STAGE)) begin
        state_d = ST_DONE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        stage_d = stage_q + 3'd1;
        b_d     = '0;
        valid_d = 1'b1;
      end
    end

    last_d = valid_d && (b_d == BF_W'(NUM_BF - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      b_q      <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      b_q      <= b_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_a_q <= w_addr_a;
      addr_b_q <= w_addr_b;
      tw_q     <= w_tw;
    end
  end

  assign bf_if.bf_valid = valid_q;
  assign bf_if.addr_a   = addr_a_q;
  assign bf_if.addr_b   = addr_b_q;
  assign bf_if.tw_idx   = tw_q;
  assign bf_if.stage    = stage_q;
  assign bf_if.last_bf  = last_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_fft32_bf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft32_bf_sequencer : directed bench for the FFT32 sequencer     |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
module tb_fft32_bf_sequencer;
  localparam int BF_LAT    = 3;
  localparam int FRAME_LEN = 1 + 5 * (16 + BF_LAT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  fft32_bf_sequencer_if bus();

  fft32_bf_sequencer #(.BF_LATENCY(BF_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .bf_if   (bus)
  );

  logic [2:0] u_stage = '0;
  logic [3:0] u_b     = '0;
  logic [4:0] u_a;
  logic [4:0] u_bb;
  logic [3:0] u_tw;

  fft32_bf_addr_gen u_ag (
    .stage_i  (u_stage),
    .b_i      (u_b),
    .addr_a_o (u_a),
    .addr_b_o (u_bb),
    .tw_idx_o (u_tw)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  int'(bus.bf_valid), 0);
    chk({tag, "_addr_a"}, int'(bus.addr_a),   0);
    chk({tag, "_addr_b"}, int'(bus.addr_b),   0);
    chk({tag, "_tw"},     int'(bus.tw_idx),   0);
    chk({tag, "_stage"},  int'(bus.stage),    0);
    chk({tag, "_last"},   int'(bus.last_bf),  0);
    chk({tag, "_busy"},   int'(busy),         0);
    chk({tag, "_done"},   int'(done),         0);
  endtask

  // Beat scoreboard: expected beat k is stage k/16, butterfly k%16
  int cyc = 0, beat_cnt = 0, last_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int zero_run = 0, t_start = 0, t_done = 0, t_busy1 = -1;
  bit prev_valid = 0, prev_done = 0;

  always @(negedge clk) begin
    int s, b, half, pos, a;
    cyc++;
    if (!rst_n) begin
      beat_cnt = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
      zero_run = 0; t_busy1 = -1; prev_valid = 0; prev_done = 0;
    end else begin
      if (start && !busy) begin
        beat_cnt = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
        zero_run = 0; t_start = cyc; t_busy1 = -1; prev_valid = 0;
      end
      chk("done_with_valid", int'(done & bus.bf_valid), 0);
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      prev_done = done;
      if (busy) begin
        busy_cnt++;
        if (t_busy1 < 0) t_busy1 = cyc;
      end
      if (bus.bf_valid) begin
        if (!prev_valid && beat_cnt > 0) chk("gap_len", zero_run, BF_LAT);
        zero_run = 0;
        if (beat_cnt >= 80) begin
          chk("extra_beat", beat_cnt, 79);
        end else begin
          s    = beat_cnt / 16;
          b    = beat_cnt % 16;
          half = 16 >> s;
          pos  = b % half;
          a    = (b / half) * 2 * half + pos;
          chk("beat_stage",  int'(bus.stage),   s);
          chk("beat_addr_a", int'(bus.addr_a),  a);
          chk("beat_addr_b", int'(bus.addr_b),  a + half);
          chk("beat_tw",     int'(bus.tw_idx),  (pos << s) % 16);
          chk("beat_last",   int'(bus.last_bf), (b == 15) ? 1 : 0);
        end
        if (bus.bf_ready) begin
          beat_cnt++;
          if (bus.last_bf) last_cnt++;
        end
      end else begin
        chk("last_when_idle", int'(bus.last_bf), 0);
        if (busy && !done) zero_run++;
      end
      if (done) begin
        done_cnt++;
        t_done = cyc;
        chk("final_gap", zero_run, BF_LAT);
      end
      prev_valid = bus.bf_valid;
    end
  end

  task automatic run_frame(input int exp_len, input bit do_stall, input bit do_mid_start);
    bit finished = 0, stalled = 0, pulsed = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (do_stall && !stalled && bus.bf_valid && bus.stage == 3'd1 && bus.addr_a == 5'd6) begin
        bus.bf_ready = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          chk("stall_valid",  int'(bus.bf_valid), 1);
          chk("stall_addr_a", int'(bus.addr_a),   6);
          chk("stall_addr_b", int'(bus.addr_b),   14);
          chk("stall_tw",     int'(bus.tw_idx),   12);
          chk("stall_stage",  int'(bus.stage),    1);
        end
        bus.bf_ready = 1'b1;
        stalled = 1;
      end
      if (do_mid_start && !pulsed && bus.bf_valid && bus.stage == 3'd3) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pulsed = 1;
      end
      if (done_cnt > 0) finished = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!finished) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_beats",     beat_cnt,          80);
    chk("frame_last_bf",   last_cnt,          5);
    chk("frame_done_cnt",  done_cnt,          1);
    chk("done_latency",    t_done - t_start,  exp_len);
    chk("busy_rise",       t_busy1 - t_start, 1);
    chk("busy_cycles",     busy_cnt,          exp_len);
    chk("idle_busy",       int'(busy),        0);
  endtask

  int tv [7][5] = '{
    '{0,  3,  3, 19,  3},
    '{2,  5,  9, 13,  4},
    '{4,  7, 14, 15,  0},
    '{1,  6,  6, 14, 12},
    '{3, 13, 25, 27,  8},
    '{0, 15, 15, 31, 15},
    '{1,  9, 17, 25,  2}
  };

  initial begin
    bit found;
    bus.bf_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      u_stage = 3'(tv[i][0]);
      u_b     = 4'(tv[i][1]);
      #1;
      chk("ag_addr_a", int'(u_a),  tv[i][2]);
      chk("ag_addr_b", int'(u_bb), tv[i][3]);
      chk("ag_tw",     int'(u_tw), tv[i][4]);
    end

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    run_frame(FRAME_LEN, 1'b0, 1'b0);
    run_frame(FRAME_LEN + 4, 1'b1, 1'b0);
    run_frame(FRAME_LEN, 1'b0, 1'b1);

    // Reset in the middle of stage 2, then a clean restart
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.bf_valid && bus.stage == 3'd2) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reach_stage2", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(FRAME_LEN, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft32_bf_sequencer.md
# fft32_bf_sequencer

Control sequencer for the 32-point radix-2 decimation-in-frequency FFT. On `start` it walks 5 stages × 16 butterflies. For each butterfly it issues the operand-pair memory addresses and the 4-bit twiddle index that selects one of the 16 twiddle ROM entries (real and imaginary ROMs share the index). It sits between the top-level frame controller and the butterfly/ROM datapath, inserts drain gaps between stages for the butterfly pipeline, and reports frame completion.

## Interface
- `BF_LATENCY`, default 3: butterfly pipeline depth in cycles. Sets the idle gap after each stage.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle frame request. Honoured only in IDLE.
- `bf_ready`  in  1  butterfly datapath can accept a beat this cycle.
- `bf_valid`  out  1  current beat (addresses + twiddle) is valid.
- `addr_a`  out  5  upper-leg operand address.
- `addr_b`  out  5  lower-leg operand address (`addr_a` + half-span).
- `tw_idx`  out  4  twiddle ROM entry select, 0..15.
- `stage`  out  3  current stage, 0..4.
- `last_bf`  out  1  beat is the last butterfly of its stage.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
  - IDLE: `start`=1 moves to RUN, with stage=0 and b=0.
  - RUN: a beat transfers on `bf_valid && bf_ready`. After a transfer with b<15, b increments. After a transfer with b=15, the FSM enters GAP.
  - GAP: counts BF_LATENCY cycles. It then returns to RUN with stage+1 and b=0, or goes to DONE if stage was 4.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Address generation for stage s and butterfly b (0..15):
  - half = 16 >> s
  - pos = b mod half, grp = b / half
  - `addr_a` = grp·2·half + pos
  - `addr_b` = `addr_a` + half
  - `tw_idx` = pos << s, truncated to 4 bits
- Implement these with shifts and masks only; no dividers.
- Output order is natural-in, bit-reversed-out. Bit reversal is not this block's job.
- `last_bf` = 1 exactly when b=15 and `bf_valid`=1.
- `start` in any state other than IDLE is ignored. A second frame needs a fresh `start` after `done`.
- Reset mid-frame returns immediately to IDLE. Nothing is resumed.

## Timing
- Reset values: `bf_valid`=0, `addr_a`=0, `addr_b`=0, `tw_idx`=0, `stage`=0, `last_bf`=0, `busy`=0, `done`=0. The FSM is in IDLE and the gap counter is 0.
- All outputs are registered.
- `start` sampled high in cycle T gives `busy`=1 and `bf_valid`=1 in T+1, carrying stage 0, b=0.
- Stall rule: while `bf_valid`=1 and `bf_ready`=0, all of `addr_a`, `addr_b`, `tw_idx`, `stage` and `last_bf` hold stable. `bf_valid` never drops without a transfer.
- With `bf_ready` held high there is one beat per cycle. Each stage therefore takes 16 cycles plus BF_LATENCY gap cycles with `bf_valid`=0.
- Unstalled frame: `start` at T gives `done` at T + 1 + 5·(16+BF_LATENCY), which is T+96 for BF_LATENCY=3.
- `busy` rises at T+1 and falls in the cycle after `done`.
- `done` and `bf_valid` are never high together.
- BF_LATENCY=0 is legal: stages run back-to-back and GAP lasts zero cycles.

## Structure
- Shared package `fft32_pkg`:
  - constants N=32, LOG2N=5, NUM_BF=16, TW_IDX_W=4, ADDR_W=5
  - FSM state enum
- Sub-module `fft32_bf_addr_gen`: pure combinational map from (stage, b) to (`addr_a`, `addr_b`, `tw_idx`). It is unit-testable on its own. The top level holds the FSM, counters and output registers.

## Test plan
- Reset, then `start`, with `bf_ready`=1 and BF_LATENCY=3 → exactly 80 valid beats; `done` at T+96; `busy` high T+1..T+96.
- Spot checks:
  - stage 0, b=3 → `addr_a`=3, `addr_b`=19, `tw_idx`=3
  - stage 2, b=5 → `addr_a`=9, `addr_b`=13, `tw_idx`=4
  - stage 4, b=7 → `addr_a`=14, `addr_b`=15, `tw_idx`=0
- Stall: drop `bf_ready` for 4 cycles at stage 1, b=6 → outputs frozen at `addr_a`=6, `addr_b`=14, `tw_idx`=12; no beat lost or repeated; `done` slips by 4 cycles.
- Gap check: between stages, `bf_valid`=0 for exactly BF_LATENCY cycles. `last_bf`=1 only on b=15 beats, 5 times per frame.
- `start` pulsed mid-frame (stage 3) → ignored; the beat sequence is unchanged and there is a single `done`.
- `rst_n` asserted during stage 2 → all outputs 0 asynchronously. A new `start` after release restarts at stage 0, b=0.
